// File: rtl/aes_block_sequencer.sv
// AES block sequencer: queues 128-bit blocks from the extractor, loads the first block after
// reset/rekey as the key, runs one start/done handshake per plaintext block with a watchdog,
// and presents each ciphertext on a valid/ready port.
module aes_block_sequencer #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  input  logic [127:0] blk_data,
  input  logic         rekey,
  input  logic         core_done,
  input  logic [127:0] core_dout,
  input  logic         out_ready,
  output logic         blk_ready,
  output logic         core_key_load,
  output logic [127:0] core_key,
  output logic         core_start,
  output logic [127:0] core_din,
  output logic         out_valid,
  output logic [127:0] out_data,
  output logic         key_valid,
  output logic         overflow,
  output logic         timeout_err,
  output logic [15:0]  blk_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = $clog2(TIMEOUT);
  // Last watchdog value seen in BUSY before the abort edge; puts timeout_err exactly
  // TIMEOUT cycles after the core_start cycle.
  localparam logic [WW-1:0] WdLast = WW'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    StNeedKey,
    StKeyLoad,
    StWaitData,
    StStart,
    StBusy,
    StOutput
  } state_e;

  state_e          state_q;
  logic [127:0]    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            rekey_pending_q;
  logic [WW-1:0]   wd_q;
  logic [127:0]    core_key_q, core_din_q, out_data_q;
  logic            key_valid_q, overflow_q, timeout_err_q;
  logic [15:0]     blk_count_q;

  logic            q_empty, q_full, push, pop;
  logic [127:0]    head;

  assign q_empty   = (count_q == '0);
  assign q_full    = (count_q == CW'(DEPTH));
  assign head      = mem_q[rd_ptr_q];
  assign blk_ready = ~q_full;

  // Pop whenever the FSM is about to consume the head block this cycle.
  always_comb begin
    pop = 1'b0;
    if (!q_empty) begin
      if (state_q == StNeedKey) pop = 1'b1;
      else if (state_q == StWaitData && !rekey_pending_q) pop = 1'b1;
    end
  end

  // A simultaneous pop frees a slot, so a full queue still accepts in that cycle.
  assign push = blk_valid & (~q_full | pop);

  // Queue storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= blk_data;
  end

  // Queue pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (blk_valid && q_full && !pop) overflow_q <= 1'b1;
    end
  end

  // Sequencing FSM with registered key/data/result registers, flags and counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StNeedKey;
      rekey_pending_q <= 1'b0;
      wd_q            <= '0;
      core_key_q      <= '0;
      core_din_q      <= '0;
      out_data_q      <= '0;
      key_valid_q     <= 1'b0;
      timeout_err_q   <= 1'b0;
      blk_count_q     <= '0;
    end else begin
      // Requests outside WAIT_DATA stay pending until WAIT_DATA acts on them.
      if (rekey) rekey_pending_q <= 1'b1;
      else if (state_q == StWaitData) rekey_pending_q <= 1'b0;

      unique case (state_q)
        StNeedKey: begin
          key_valid_q <= 1'b0;
          if (!q_empty) begin
            core_key_q <= head;
            state_q    <= StKeyLoad;
          end
        end
        StKeyLoad: begin
          key_valid_q <= 1'b1;
          state_q     <= StWaitData;
        end
        StWaitData: begin
          if (rekey_pending_q) begin
            key_valid_q <= 1'b0;
            state_q     <= StNeedKey;
          end else if (!q_empty) begin
            core_din_q <= head;
            state_q    <= StStart;
          end
        end
        StStart: begin
          wd_q    <= '0;
          state_q <= StBusy;
        end
        StBusy: begin
          if (core_done) begin
            out_data_q <= core_dout;
            state_q    <= StOutput;
          end else if (wd_q == WdLast) begin
            timeout_err_q <= 1'b1;
            state_q       <= StWaitData;
          end else begin
            wd_q <= wd_q + WW'(1);
          end
        end
        StOutput: begin
          if (out_ready) begin
            blk_count_q <= blk_count_q + 16'd1;
            state_q     <= StWaitData;
          end
        end
        default: state_q <= StNeedKey;
      endcase
    end
  end

  assign core_key_load = (state_q == StKeyLoad);
  assign core_start    = (state_q == StStart);
  assign out_valid     = (state_q == StOutput);
  assign core_key      = core_key_q;
  assign core_din      = core_din_q;
  assign out_data      = out_data_q;
  assign key_valid     = key_valid_q;
  assign overflow      = overflow_q;
  assign timeout_err   = timeout_err_q;
  assign blk_count     = blk_count_q;

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Self-checking bench for aes_block_sequencer: table-driven key/plaintext vectors, directed
// multi-cycle sequences (overflow, rekey, watchdog, async reset, counter wrap) and a randomized
// stream checked against a block-level model. A mock core answers core_start after a set latency.
module tb_aes_block_sequencer;

  localparam int unsigned Depth   = 2;
  localparam int unsigned Timeout = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         blk_valid;
  logic [127:0] blk_data;
  logic         rekey;
  logic         core_done = 1'b0;
  logic [127:0] core_dout = '0;
  logic         out_ready;
  logic         blk_ready;
  logic         core_key_load;
  logic [127:0] core_key;
  logic         core_start;
  logic [127:0] core_din;
  logic         out_valid;
  logic [127:0] out_data;
  logic         key_valid;
  logic         overflow;
  logic         timeout_err;
  logic [15:0]  blk_count;

  aes_block_sequencer #(
    .DEPTH  (Depth),
    .TIMEOUT(Timeout)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .blk_valid    (blk_valid),
    .blk_data     (blk_data),
    .rekey        (rekey),
    .core_done    (core_done),
    .core_dout    (core_dout),
    .out_ready    (out_ready),
    .blk_ready    (blk_ready),
    .core_key_load(core_key_load),
    .core_key     (core_key),
    .core_start   (core_start),
    .core_din     (core_din),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .key_valid    (key_valid),
    .overflow     (overflow),
    .timeout_err  (timeout_err),
    .blk_count    (blk_count)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] K0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  int n_checks  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int exp_count = 0;
  logic [127:0] exp_q[$];

  // Mock core: known AES vector for K0/P0, otherwise plaintext XOR key.
  function automatic logic [127:0] mock_fn(input logic [127:0] k, input logic [127:0] p);
    if (k == K0 && p == P0) return CT0;
    return p ^ k;
  endfunction

  int           mock_lat  = 4;
  bit           mock_rand = 1'b0;
  bit           armed     = 1'b0;
  int           mcnt      = 0;
  logic [127:0] m_key, m_din;
  logic [127:0] start_log[$];

  // Answers each core_start with a one-cycle done after mcnt cycles; latency 0 never answers.
  always @(posedge clk) begin
    #1;
    core_done = 1'b0;
    if (armed) begin
      mcnt--;
      if (mcnt == 0) begin
        core_done = 1'b1;
        core_dout = mock_fn(m_key, m_din);
        armed     = 1'b0;
      end
    end
    if (core_start) begin
      start_log.push_back(core_din);
      m_key = core_key;
      m_din = core_din;
      mcnt  = mock_rand ? int'($urandom_range(1, 6)) : mock_lat;
      armed = (mcnt != 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check1({tag, " core_key_load"}, core_key_load, 1'b0);
    check1({tag, " core_start"}, core_start, 1'b0);
    check1({tag, " out_valid"}, out_valid, 1'b0);
    check1({tag, " key_valid"}, key_valid, 1'b0);
    check1({tag, " overflow"}, overflow, 1'b0);
    check1({tag, " timeout_err"}, timeout_err, 1'b0);
    check1({tag, " blk_ready"}, blk_ready, 1'b1);
    check128({tag, " core_key"}, core_key, '0);
    check128({tag, " core_din"}, core_din, '0);
    check128({tag, " out_data"}, out_data, '0);
    checkn({tag, " blk_count"}, int'(blk_count), 0);
  endtask

  task automatic send_block(input logic [127:0] d);
    blk_valid = 1'b1;
    blk_data  = d;
    tick();
    blk_valid = 1'b0;
  endtask

  // Key block sent in NEED_KEY: load pulse two cycles later, key_valid follows.
  task automatic load_key(input logic [127:0] k, input string tag);
    send_block(k);
    tick();
    check1({tag, " key_load pulse"}, core_key_load, 1'b1);
    check128({tag, " core_key"}, core_key, k);
    check1({tag, " key_valid low in load"}, key_valid, 1'b0);
    tick();
    check1({tag, " key_load one cycle"}, core_key_load, 1'b0);
    check1({tag, " key_valid set"}, key_valid, 1'b1);
  endtask

  // Plaintext into an empty queue in WAIT_DATA, then one output accepted.
  task automatic run_pt(input logic [127:0] p, input logic [127:0] ct, input int lat,
                        input string tag);
    int s;
    int w;
    mock_lat = lat;
    send_block(p);
    tick();
    check1({tag, " core_start at t+2"}, core_start, 1'b1);
    check128({tag, " core_din"}, core_din, p);
    s = cyc;
    tick();
    check1({tag, " start one cycle"}, core_start, 1'b0);
    w = 0;
    while (!out_valid && w < int'(Timeout) + 8) begin
      tick();
      w++;
    end
    checkn({tag, " out_valid latency"}, cyc - s, lat + 1);
    check128({tag, " out_data"}, out_data, ct);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_count++;
    check1({tag, " out_valid drops"}, out_valid, 1'b0);
    checkn({tag, " blk_count"}, int'(blk_count), exp_count);
  endtask

  task automatic drain(input int n, input string tag);
    int w;
    w = 0;
    while (n > 0 && w < 2000) begin
      out_ready = 1'b1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s: got unexpected output %h", tag, out_data);
        end else begin
          check128(tag, out_data, exp_q.pop_front());
        end
        exp_count++;
        n--;
      end
      tick();
      w++;
    end
    out_ready = 1'b0;
    if (n > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got %0d outputs missing, expected 0 missing", tag, n);
    end
  endtask

  task automatic do_rekey(input string tag);
    rekey = 1'b1;
    tick();
    rekey = 1'b0;
    tick();
    tick();
    check1({tag, " key_valid cleared"}, key_valid, 1'b0);
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    int           lat;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #1_000_000;
    $display("FAIL global time limit: simulation still running");
    $fatal(1, "time limit");
  end

  initial begin
    logic [127:0] kb, k2, ka, kx;
    logic [127:0] blks[40];
    int s, w, sent, got;
    bit seen_ov;

    vecs[0] = '{K0, P0, CT0, 10};
    vecs[1] = '{128'hffffffffffffffffffffffffffffffff, 128'h0123456789abcdef0123456789abcdef,
                128'hfedcba9876543210fedcba9876543210, 3};
    vecs[2] = '{128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5, 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a,
                128'hffffffffffffffffffffffffffffffff, 1};
    vecs[3] = '{128'h0, 128'hdeadbeefcafef00d1234567890abcdef,
                128'hdeadbeefcafef00d1234567890abcdef, int'(Timeout) - 2};

    rst = 1'b1; blk_valid = 1'b0; blk_data = '0; rekey = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    check_idle("reset");
    rst = 1'b0;
    tick();

    // Table: key load then one encryption per vector, rekeying between vectors.
    for (int i = 0; i < 4; i++) begin
      if (i != 0) do_rekey($sformatf("vec%0d", i));
      load_key(vecs[i].key, $sformatf("vec%0d", i));
      run_pt(vecs[i].pt, vecs[i].ct, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Back-to-back: queue fills while the core is busy, 4th block is dropped.
    kb = 128'h0f0e0d0c0b0a09080706050403020100;
    do_rekey("b2b");
    load_key(kb, "b2b");
    start_log.delete();
    mock_lat  = 20;
    blk_valid = 1'b1;
    blk_data  = 128'haaaa0000000000000000000000000001; tick();
    blk_data  = 128'hbbbb0000000000000000000000000002; tick();
    blk_data  = 128'hcccc0000000000000000000000000003; tick();
    check1("b2b blk_ready full", blk_ready, 1'b0);
    check1("b2b overflow before drop", overflow, 1'b0);
    blk_data  = 128'hdddd0000000000000000000000000004; tick();
    blk_valid = 1'b0;
    check1("b2b overflow set", overflow, 1'b1);
    repeat (30) tick();
    mock_lat = 2;
    check1("b2b out_valid held", out_valid, 1'b1);
    check128("b2b out_data held", out_data, 128'haaaa0000000000000000000000000001 ^ kb);
    exp_q.push_back(128'haaaa0000000000000000000000000001 ^ kb);
    exp_q.push_back(128'hbbbb0000000000000000000000000002 ^ kb);
    exp_q.push_back(128'hcccc0000000000000000000000000003 ^ kb);
    drain(3, "b2b out");
    checkn("b2b starts", start_log.size(), 3);
    if (start_log.size() == 3)
      check128("b2b third din", start_log[2], 128'hcccc0000000000000000000000000003);
    checkn("b2b blk_count", int'(blk_count), exp_count);
    check1("b2b overflow sticky", overflow, 1'b1);

    // Rekey during BUSY: current block finishes under the old key, then K2 loads.
    k2 = 128'h2222222222222222333333333333333a;
    mock_lat = 8;
    send_block(128'h10101010101010101010101010101010);
    tick();
    check1("rk start", core_start, 1'b1);
    tick();
    rekey = 1'b1;
    tick();
    rekey = 1'b0;
    send_block(k2);
    send_block(128'h44444444444444445555555555555555);
    exp_q.push_back(128'h10101010101010101010101010101010 ^ kb);
    drain(1, "rk old-key out");
    w = 0;
    while (!core_key_load && w < 20) begin
      tick();
      w++;
    end
    check1("rk key_load seen", core_key_load, 1'b1);
    check128("rk core_key", core_key, k2);
    check1("rk key_valid low", key_valid, 1'b0);
    tick();
    check1("rk key_valid high", key_valid, 1'b1);
    exp_q.push_back(128'h44444444444444445555555555555555 ^ k2);
    drain(1, "rk new-key out");

    // Watchdog: core never answers.
    mock_lat = 0;
    check1("wd err clear before", timeout_err, 1'b0);
    send_block(128'h77777777777777777777777777777777);
    tick();
    check1("wd start", core_start, 1'b1);
    s = cyc;
    w = 0;
    seen_ov = 1'b0;
    while (!timeout_err && w < int'(Timeout) + 10) begin
      tick();
      w++;
      if (out_valid) seen_ov = 1'b1;
    end
    checkn("wd fire delay", cyc - s, int'(Timeout));
    check1("wd no output", seen_ov, 1'b0);
    checkn("wd blk_count unchanged", int'(blk_count), exp_count);
    mock_lat = 3;
    send_block(128'h88888888888888888888888888888888);
    tick();
    check1("wd next start", core_start, 1'b1);
    check128("wd next din", core_din, 128'h88888888888888888888888888888888);
    exp_q.push_back(128'h88888888888888888888888888888888 ^ k2);
    drain(1, "wd next out");
    check1("wd err sticky", timeout_err, 1'b1);

    // Async reset mid-operation with one block still queued.
    mock_lat = 0;
    send_block(128'h99999999999999999999999999999999);
    tick();
    send_block(128'h12121212121212121212121212121212);
    #2;
    rst = 1'b1;
    #1;
    check_idle("midrst");
    tick();
    rst = 1'b0;
    exp_count = 0;
    tick();
    kx = 128'h3c3c3c3c3c3c3c3cc3c3c3c3c3c3c3c3;
    load_key(kx, "postrst");

    // Counter wrap 0xFFFE -> 0xFFFF -> 0x0000.
    force dut.blk_count_q = 16'hfffe;
    tick();
    release dut.blk_count_q;
    checkn("wrap preload", int'(blk_count), 16'hfffe);
    exp_count = 16'hfffe;
    run_pt(128'h0000000000000000000000000000abcd, 128'h0000000000000000000000000000abcd ^ kx,
           2, "wrap1");
    exp_count = -1;
    run_pt(128'h000000000000000000000000000000ef, 128'h000000000000000000000000000000ef ^ kx,
           2, "wrap2");

    // Random stream: first block is the key, the rest are plaintext in arrival order.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    exp_q.delete();
    mock_rand = 1'b1;
    for (int i = 0; i < 40; i++) blks[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    ka = blks[0];
    for (int i = 1; i < 40; i++) exp_q.push_back(blks[i] ^ ka);
    sent = 0;
    got  = 0;
    w    = 0;
    while (got < 39 && w < 5000) begin
      blk_valid = 1'b0;
      if (sent < 40 && blk_ready && $urandom_range(0, 2) != 0) begin
        blk_valid = 1'b1;
        blk_data  = blks[sent];
        sent++;
      end
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        check128($sformatf("rand out %0d", got), out_data, exp_q.pop_front());
        got++;
      end
      tick();
      w++;
    end
    blk_valid = 1'b0;
    out_ready = 1'b0;
    checkn("rand outputs", got, 39);
    checkn("rand blk_count", int'(blk_count), 39);
    check1("rand no overflow", overflow, 1'b0);
    check1("rand no timeout", timeout_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
